// File: rtl/alu_flag_unit.sv
// NZCV status register with ARM-style condition evaluation and shadow save/restore.
// Optional FLAG_OVF_CNT_EN builds a saturating counter of committed signed overflows.
module alu_flag_unit #(
    parameter int unsigned P     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             Valid,
    input  logic [P-1:0]     Result,
    input  logic [2:0]       ALUControl,
    input  logic             Cout,
    input  logic             A_msb,
    input  logic             B_msb,
    input  logic [1:0]       FlagWrite,
    input  logic [3:0]       Cond,
    input  logic             Save,
    input  logic             Restore,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [3:0]       FlagsNext,
    output logic [3:0]       SavedFlags,
    output logic [CNT_W-1:0] OvfCount
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    logic is_add;
    logic is_sub;
    logic n_nxt;
    logic z_nxt;
    logic c_nxt;
    logic v_nxt;
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic commit;

    assign is_add = (ALUControl == OP_ADD);
    assign is_sub = (ALUControl == OP_SUB);

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    // Candidate flags; logic-class ops carry C and V through from the register
    always_comb begin
        n_nxt = Result[P-1];
        z_nxt = (Result == '0);
        c_nxt = flag_c;
        v_nxt = flag_v;
        if (is_add) begin
            c_nxt = Cout;
            v_nxt = (A_msb == B_msb) & (Result[P-1] != A_msb);
        end else if (is_sub) begin
            c_nxt = Cout;
            v_nxt = (A_msb != B_msb) & (Result[P-1] != A_msb);
        end
    end

    assign FlagsNext = {n_nxt, z_nxt, c_nxt, v_nxt};

    // Condition check sees only registered flags, so no loop through FlagsNext
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flag_z;
            4'b0001: CondEx = ~flag_z;
            4'b0010: CondEx = flag_c;
            4'b0011: CondEx = ~flag_c;
            4'b0100: CondEx = flag_n;
            4'b0101: CondEx = ~flag_n;
            4'b0110: CondEx = flag_v;
            4'b0111: CondEx = ~flag_v;
            4'b1000: CondEx = flag_c & ~flag_z;
            4'b1001: CondEx = ~flag_c | flag_z;
            4'b1010: CondEx = (flag_n == flag_v);
            4'b1011: CondEx = (flag_n != flag_v);
            4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
            4'b1101: CondEx = flag_z | (flag_n != flag_v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign commit = en & ~flush & Valid & CondEx;

    // Restore outranks commit; Save and Restore together swap the two registers
    always_ff @(posedge clk) begin
        if (rst) begin
            Flags      <= 4'b0000;
            SavedFlags <= 4'b0000;
        end else if (en) begin
            if (Save && !flush) begin
                SavedFlags <= Flags;
            end
            if (Restore) begin
                Flags <= SavedFlags;
            end else if (commit) begin
                if (FlagWrite[1]) begin
                    Flags[3:2] <= FlagsNext[3:2];
                end
                if (FlagWrite[0]) begin
                    Flags[1:0] <= FlagsNext[1:0];
                end
            end
        end
    end

`ifdef FLAG_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt;
    logic             ovf_inc;

    assign ovf_inc = commit & ~Restore & FlagWrite[0] & (is_add | is_sub) & v_nxt;

    // Saturating count of committed arithmetic overflows
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_inc && !(&ovf_cnt)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

    assign OvfCount = ovf_cnt;
`else
    assign OvfCount = '0;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Table-driven bench for alu_flag_unit with a queue of expected register state.
module tb_alu_flag_unit;

    localparam int unsigned P     = 32;
    localparam int unsigned CNT_W = 8;
`ifdef FLAG_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] MOV = 3'b101;

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic             Valid;
    logic [P-1:0]     Result;
    logic [2:0]       ALUControl;
    logic             Cout;
    logic             A_msb;
    logic             B_msb;
    logic [1:0]       FlagWrite;
    logic [3:0]       Cond;
    logic             Save;
    logic             Restore;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [3:0]       FlagsNext;
    logic [3:0]       SavedFlags;
    logic [CNT_W-1:0] OvfCount;

    alu_flag_unit #(.P(P), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .Valid(Valid),
        .Result(Result), .ALUControl(ALUControl), .Cout(Cout),
        .A_msb(A_msb), .B_msb(B_msb), .FlagWrite(FlagWrite), .Cond(Cond),
        .Save(Save), .Restore(Restore), .CondEx(CondEx), .Flags(Flags),
        .FlagsNext(FlagsNext), .SavedFlags(SavedFlags), .OvfCount(OvfCount)
    );

    typedef struct {
        bit         rst, en, flush, valid;
        logic [2:0] op;
        logic [31:0] res;
        bit         cout, am, bm;
        logic [1:0] fw;
        logic [3:0] cond;
        bit         save, restore;
        bit         chk_comb;
        bit         exp_cx;
        logic [3:0] exp_next;
        logic [3:0] exp_f;
        logic [3:0] exp_s;
        logic [7:0] exp_o;
    } vec_t;

    typedef struct {
        logic [3:0] f;
        logic [3:0] s;
        logic [7:0] o;
    } exp_t;

    int   tests  = 0;
    int   failed = 0;
    vec_t tbl[$];
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit r, input bit e, input bit fl, input bit vl,
                                input logic [2:0] op, input logic [31:0] res,
                                input bit co, input bit am, input bit bm,
                                input logic [1:0] fw, input logic [3:0] cond,
                                input bit sv, input bit rs, input bit chk, input bit cx,
                                input logic [3:0] nx, input logic [3:0] f,
                                input logic [3:0] s, input logic [7:0] o);
        vec_t v;
        v.rst = r; v.en = e; v.flush = fl; v.valid = vl; v.op = op; v.res = res;
        v.cout = co; v.am = am; v.bm = bm; v.fw = fw; v.cond = cond;
        v.save = sv; v.restore = rs; v.chk_comb = chk; v.exp_cx = cx;
        v.exp_next = nx; v.exp_f = f; v.exp_s = s; v.exp_o = o;
        return v;
    endfunction

    function automatic logic [7:0] ov(input int n);
        return OVF_EN ? 8'(n) : 8'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        rst = v.rst; en = v.en; flush = v.flush; Valid = v.valid;
        ALUControl = v.op; Result = v.res; Cout = v.cout; A_msb = v.am; B_msb = v.bm;
        FlagWrite = v.fw; Cond = v.cond; Save = v.save; Restore = v.restore;
        #1;
        if (v.chk_comb) begin
            chk({tag, " condex"}, 32'(CondEx), 32'(v.exp_cx));
            chk({tag, " flagsnext"}, 32'(FlagsNext), 32'(v.exp_next));
        end
        sb.push_back('{v.exp_f, v.exp_s, v.exp_o});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " flags"}, 32'(Flags), 32'(e.f));
        chk({tag, " saved"}, 32'(SavedFlags), 32'(e.s));
        chk({tag, " ovfcount"}, 32'(OvfCount), 32'(e.o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; Valid = 1'b0; Result = '0; ALUControl = ADD;
        Cout = 1'b0; A_msb = 1'b0; B_msb = 1'b0; FlagWrite = 2'b00; Cond = 4'b0000;
        Save = 1'b0; Restore = 1'b0;
        @(posedge clk);
        #1;

        //             rst en fl vl op   result        co am bm fw     cond    sv rs ck cx next     flags    saved    ovf
        tbl.push_back(mk(1, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0000, 0, 0, 1, 0, 4'b0100, 4'b0000, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0001, 0, 0, 1, 1, 4'b0100, 4'b0000, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1111, 0, 0, 1, 0, 4'b0100, 4'b0000, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h0,        1, 1, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0110, 4'b0110, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0000, 0, 0, 1, 1, 4'b0100, 4'b0110, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b1001, 4'b1001, 4'b0000, ov(1)));
        // Condition codes against N=1 Z=0 C=0 V=1
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1010, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1011, 0, 0, 1, 0, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1100, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1101, 0, 0, 1, 0, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1000, 0, 0, 1, 0, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1001, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0100, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0101, 0, 0, 1, 0, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0110, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0111, 0, 0, 1, 0, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0011, 0, 0, 1, 1, 4'b0100, 4'b1001, 4'b0000, ov(1)));
        // Flags=0100, then suppressed SUB via failed cond, flush and stall
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h0,        0, 1, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0100, 4'b0100, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, SUB, 32'h1,        1, 0, 0, 2'b11, 4'b0001, 0, 0, 1, 0, 4'b0010, 4'b0100, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 1, 1, SUB, 32'h1,        1, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0010, 4'b0100, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 0, 0, 1, SUB, 32'h1,        1, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0010, 4'b0100, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 0, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 1, 1, 1, 1, 4'b0100, 4'b0100, 4'b0000, ov(1)));
        // Save, logic op, restore
        tbl.push_back(mk(0, 1, 0, 1, MOV, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b1000, 4'b1000, 4'b0000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 1, 0, 1, 1, 4'b0100, 4'b1000, 4'b1000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, AND, 32'h5,        0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0000, 4'b0000, 4'b1000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 0, 1, 1, 1, 4'b0100, 4'b1000, 4'b1000, ov(1)));
        // Partial FlagWrite, then swap
        tbl.push_back(mk(0, 1, 0, 1, SUB, 32'h0,        1, 0, 1, 2'b01, 4'b1110, 0, 0, 1, 1, 4'b0110, 4'b1010, 4'b1000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h1,        0, 0, 0, 2'b10, 4'b1110, 0, 0, 1, 1, 4'b0000, 4'b0010, 4'b1000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1000, 0, 0, 1, 1, 4'b0100, 4'b0010, 4'b1000, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 1, 1, 1, 1, 4'b0100, 4'b1000, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 0, 1, 1, 1, 4'b0100, 4'b0010, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, AND, 32'h0,        0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b0110, 4'b0110, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 1, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b1110, 1, 0, 1, 1, 4'b0100, 4'b0110, 4'b0010, ov(1)));
        // Overflow events that must not count, then ones that must
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 1, 1, 1, 4'b1001, 4'b0010, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 1, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b1001, 4'b0010, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b10, 4'b1110, 0, 0, 1, 1, 4'b1001, 4'b1010, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 1, 0, 4'b1001, 4'b1010, 4'b0010, ov(1)));
        tbl.push_back(mk(0, 1, 0, 1, SUB, 32'h80000000, 0, 0, 1, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b1001, 4'b1001, 4'b0010, ov(2)));
        tbl.push_back(mk(0, 1, 0, 1, MOV, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1, 4'b1001, 4'b1001, 4'b0010, ov(2)));
        // Reset mid-sequence wins over stall and pending commit/save
        tbl.push_back(mk(1, 0, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 1, 0, 1, 1, 4'b1001, 4'b0000, 4'b0000, ov(0)));
        tbl.push_back(mk(0, 1, 0, 0, ADD, 32'h0,        0, 0, 0, 2'b00, 4'b0001, 0, 0, 1, 1, 4'b0100, 4'b0000, 4'b0000, ov(0)));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back overflowing ADDs drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            apply(mk(0, 1, 0, 1, ADD, 32'h80000000, 0, 0, 0, 2'b11, 4'b1110, 0, 0, 1, 1,
                     4'b1001, 4'b1001, 4'b0000, ov((i + 1 > 255) ? 255 : i + 1)),
                  $sformatf("sat%0d", i));
        end
        apply(mk(0, 1, 0, 0, ADD, 32'h0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 1, 1,
                 4'b0100, 4'b1001, 4'b0000, ov(255)), "sat_hold");
        apply(mk(1, 1, 0, 0, ADD, 32'h0, 0, 0, 0, 2'b00, 4'b1110, 0, 0, 1, 1,
                 4'b0100, 4'b0000, 4'b0000, ov(0)), "sat_clear");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
